alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter N, default 64: datapath width; also the step count of every multi-cycle operation; legal range 4..128.
REQ-002 Parameter CW, default 4: alucontrol width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  1  aluop/funct carry a live instruction this cycle.
REQ-006 aluop  input  2  main-decoder ALU class (00 mem, 01 branch/move, 10 R-type).
REQ-007 funct  input  11  R-type opcode field.
REQ-008 alucontrol  output  CW  ALU operation code for the current cycle.
REQ-009 stall  output  1  holds the pipeline front end while a multi-cycle operation runs.
REQ-010 step_en  output  1  iterative datapath performs one step this cycle.
REQ-011 last_step  output  1  current step is the final (N-th) step.
REQ-012 done  output  1  single-cycle pulse: multi-cycle result valid.
REQ-013 illegal  output  1  single-cycle pulse: unrecognised funct with aluop=10 and valid_i=1.

Function
REQ-014 Codes: aluop=00 -> 0010; aluop=01 -> 0111; aluop=11 -> 0000.
REQ-015 R-type codes: ADD 10001011000 -> 0010; SUB 11001011000 -> 0110; AND 10001010000 -> 0000; ORR 10101010000 -> 0001; LSL 11010011011 -> 0011; LSR 11010011010 -> 0100.
REQ-016 Multi-cycle R-type codes: MUL 10011011000 -> 1000; UDIV 10011010110 -> 1001.
REQ-017 Unrecognised R-type funct -> alucontrol 0000, illegal=1 for that cycle, no state change.
REQ-018 States: IDLE, MUL, DIV, DONE.
REQ-019 IDLE: alucontrol is the combinational decode of the current inputs; stall=0, step_en=0, done=0 unless REQ-020 applies.
REQ-020 IDLE with valid_i=1 and a MUL/UDIV funct (accept cycle k): stall=1 in the same cycle, alucontrol=the op code, step counter cleared, next state MUL or DIV respectively.
REQ-021 MUL/DIV: alucontrol held at the latched code, stall=1, step_en=1, counter increments every cycle; step cycles are k+1..k+N.
REQ-022 Counter width $clog2(N); last_step=1 exactly when counter = N-1; at that cycle next state is DONE and counter wraps to 0.
REQ-023 DONE (cycle k+N+1): stall=0, step_en=0, done=1, alucontrol = latched code; next state IDLE.
REQ-024 Total stall duration is N+1 cycles (k..k+N); done follows with zero gap.
REQ-025 valid_i, aluop and funct are ignored in MUL, DIV and DONE; a new instruction is accepted only in IDLE (back-to-back MUL: second accept no earlier than k+N+2).
REQ-026 illegal is never asserted outside IDLE.
REQ-027 valid_i=0 in IDLE: alucontrol still decodes the inputs, no state change, illegal=0.

Reset
REQ-028 reset=1 forces, from the next edge on: state IDLE, counter 0, latched code 0000.
REQ-029 While reset=1 all outputs are held: alucontrol=0000, stall=0, step_en=0, last_step=0, done=0, illegal=0, regardless of other inputs.
REQ-030 reset asserted mid-MUL/DIV or in DONE aborts the operation with no done pulse; the first cycle after deassertion behaves as IDLE.

Structure
REQ-031 Package alu_pkg holds the alucontrol code constants, funct opcode constants, aluop encodings and the state enum; this module and the main decoder import it.
REQ-032 Combinational funct/aluop decode lives in one sub-module, alu_funct_decode, which outputs the code, a multi-cycle flag and an illegal flag; the sequencer instantiates it once.
REQ-033 One FSM state register, one counter, one latched-code register; no other storage.

Verification (bench uses N=8)
REQ-034 aluop=10, funct=ADD, SUB, AND, ORR, LSL, LSR, valid_i=1 -> alucontrol 0010, 0110, 0000, 0001, 0011, 0100 in the same cycle, stall=0.
REQ-035 MUL accepted at cycle 0 -> stall=1 cycles 0..8, step_en=1 cycles 1..8, last_step=1 only at cycle 8, done=1 only at cycle 9, alucontrol=1000 cycles 0..9.
REQ-036 UDIV accepted while funct toggles to SUB during cycles 1..8 -> alucontrol stays 1001 throughout, done at cycle 9, no second accept before cycle 10.
REQ-037 aluop=10, funct=11111111111, valid_i=1 -> alucontrol 0000, illegal=1 one cycle, state stays IDLE.
REQ-038 MUL accepted at cycle 0, reset=1 at cycle 4 -> from cycle 5 state IDLE, stall=0, no done pulse; new ADD at cycle 6 after deassertion decodes to 0010.
REQ-039 aluop=00 and 01 with arbitrary funct -> 0010 and 0111, no stall, no illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU control path: main-decoder aluop classes,
// R-type funct opcodes, the alucontrol codes those map to, and the state
// type of the multi-cycle operation sequencer.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Main-decoder ALU classes carried on aluop
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_OTHER  = 2'b11;

  // R-type funct opcodes
  localparam logic [10:0] FUNCT_ADD  = 11'b10001011000;
  localparam logic [10:0] FUNCT_SUB  = 11'b11001011000;
  localparam logic [10:0] FUNCT_AND  = 11'b10001010000;
  localparam logic [10:0] FUNCT_ORR  = 11'b10101010000;
  localparam logic [10:0] FUNCT_LSL  = 11'b11010011011;
  localparam logic [10:0] FUNCT_LSR  = 11'b11010011010;
  localparam logic [10:0] FUNCT_MUL  = 11'b10011011000;
  localparam logic [10:0] FUNCT_UDIV = 11'b10011010110;

  // alucontrol codes
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_UDIV  = 4'b1001;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// ---------------------------------------------------------------------------
// alu_funct_decode
// Purely combinational aluop/funct decoder.
// Ports:
//   i_aluop   - main-decoder ALU class
//   i_funct   - R-type opcode field
//   o_code    - alucontrol code for these inputs
//   o_multi   - operation needs the iterative multi-cycle datapath
//   o_illegal - R-type class with an unrecognised funct
// ---------------------------------------------------------------------------
module alu_funct_decode
  import alu_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [1:0]    i_aluop,
  input  logic [10:0]   i_funct,
  output logic [CW-1:0] o_code,
  output logic          o_multi,
  output logic          o_illegal
);

  // Map the ALU class first; only the R-type class looks at funct.
  // Unknown R-type opcodes fall back to code 0000 and raise the illegal flag;
  // whether that flag matters (valid instruction, idle sequencer) is decided
  // by the sequencer.
  always_comb begin
    o_code    = CW'(ALU_AND);
    o_multi   = 1'b0;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_MEM:    o_code = CW'(ALU_ADD);
      ALUOP_BRANCH: o_code = CW'(ALU_PASSB);
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD:  o_code = CW'(ALU_ADD);
          FUNCT_SUB:  o_code = CW'(ALU_SUB);
          FUNCT_AND:  o_code = CW'(ALU_AND);
          FUNCT_ORR:  o_code = CW'(ALU_ORR);
          FUNCT_LSL:  o_code = CW'(ALU_LSL);
          FUNCT_LSR:  o_code = CW'(ALU_LSR);
          FUNCT_MUL: begin
            o_code  = CW'(ALU_MUL);
            o_multi = 1'b1;
          end
          FUNCT_UDIV: begin
            o_code  = CW'(ALU_UDIV);
            o_multi = 1'b1;
          end
          default: begin
            o_code    = CW'(ALU_AND);
            o_illegal = 1'b1;
          end
        endcase
      end
      default: o_code = CW'(ALU_AND);
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// ALU control unit that decodes aluop/funct every cycle and sequences the
// N-step multiply and unsigned-divide operations of an iterative datapath.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   valid_i     - aluop/funct carry a live instruction
//   aluop       - main-decoder ALU class
//   funct       - R-type opcode field
//   alucontrol  - ALU operation code for the current cycle
//   stall       - hold the pipeline front end (accept cycle + N step cycles)
//   step_en     - iterative datapath performs one step
//   last_step   - current step is the N-th
//   done        - one-cycle pulse, multi-cycle result valid
//   illegal     - one-cycle pulse, unrecognised R-type funct while idle
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [1:0]    aluop,
  input  logic [10:0]   funct,
  output logic [CW-1:0] alucontrol,
  output logic          stall,
  output logic          step_en,
  output logic          last_step,
  output logic          done,
  output logic          illegal
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [CW-1:0]    r_code;

  logic [CW-1:0]    w_decCode;
  logic             w_decMulti;
  logic             w_decIllegal;
  logic             w_accept;
  logic             w_stepping;
  logic             w_lastCount;

  alu_funct_decode #(
    .CW(CW)
  ) u_decode (
    .i_aluop  (aluop),
    .i_funct  (funct),
    .o_code   (w_decCode),
    .o_multi  (w_decMulti),
    .o_illegal(w_decIllegal)
  );

  assign w_accept    = (r_state == ST_IDLE) && valid_i && w_decMulti;
  assign w_stepping  = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_lastCount = w_stepping && (r_count == LAST_COUNT);

  // Next-state logic. Inputs only matter in IDLE; once an operation is
  // accepted the sequence runs N step cycles and one DONE cycle regardless
  // of what arrives on valid_i/aluop/funct.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = (w_decCode == CW'(ALU_MUL)) ? ST_MUL : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_lastCount) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, step counter and latched code. The code is captured on the
  // accept cycle so later funct changes cannot disturb the running op; the
  // counter is cleared on accept and wraps to 0 on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_count <= '0;
        r_code  <= w_decCode;
      end else if (w_stepping) begin
        r_count <= w_lastCount ? '0 : r_count + 1'b1;
      end
    end
  end

  // Output decode. Everything is forced low while reset is high so the
  // front end sees a quiet control unit during reset, independent of the
  // registered state.
  always_comb begin
    alucontrol = '0;
    stall      = 1'b0;
    step_en    = 1'b0;
    last_step  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          alucontrol = w_decCode;
          stall      = w_accept;
          illegal    = valid_i && w_decIllegal;
        end
        ST_MUL, ST_DIV: begin
          alucontrol = r_code;
          stall      = 1'b1;
          step_en    = 1'b1;
          last_step  = w_lastCount;
        end
        ST_DONE: begin
          alucontrol = r_code;
          done       = 1'b1;
        end
        default: alucontrol = '0;
      endcase
    end
  end

endmodule
